// File: rtl/fltr_bounce_gen_pkg.sv
// Shared types and constants for the filter bounce stimulus generator.
// Holds the LFSR polynomial, its default seed and the sequencer state encoding.
package fltr_bounce_gen_pkg;

  typedef logic [3:0]  u4_t;
  typedef logic [7:0]  u8_t;
  typedef logic [31:0] u32_t;

  localparam u32_t LFSR_POLY         = 32'h8020_0003;
  localparam u32_t LFSR_SEED_DEFAULT = 32'hACE1_0001;

  typedef enum u4_t {
    ST_IDLE   = 4'd0,
    ST_SEG    = 4'd1,
    ST_SETTLE = 4'd2,
    ST_DONE   = 4'd3
  } state_e;

  // Right-shifting Galois step; the polynomial taps are XORed in when bit 0 falls out.
  function automatic u32_t lfsr_next(input u32_t q);
    return q[0] ? ((q >> 1) ^ LFSR_POLY) : (q >> 1);
  endfunction

endpackage

// File: rtl/fltr_lfsr32.sv
// Free-running 32-bit Galois LFSR, restarted from SEED by reset.
// Advances every cycle so a generator's random choices repeat relative to reset.
module fltr_lfsr32
  import fltr_bounce_gen_pkg::*;
#(
  parameter u32_t SEED = LFSR_SEED_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output u32_t q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= SEED;
    else        q <= lfsr_next(q);
  end

endmodule

// File: rtl/fltr_bounce_gen.sv
// Bounce burst generator for the single-bit filter input: N glitches, a clean
// final edge onto the target level, then a settle hold and a one-cycle done pulse.
module fltr_bounce_gen
  import fltr_bounce_gen_pkg::*;
#(
  parameter int   W_CNT       = 16,
  parameter u32_t LFSR_SEED   = 32'hACE1_0001,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             level_i,
  input  u8_t              n_bounce_i,
  input  logic [W_CNT-1:0] max_width_i,
  input  logic [W_CNT-1:0] settle_i,
  input  logic             rand_en_i,
  output logic             sig_o,
  output logic             busy_o,
  output logic             done_o,
  output u8_t              edges_o
);

  typedef logic [W_CNT-1:0] cnt_t;

  state_e     state_q, state_d;
  logic       sig_q, sig_d;
  u8_t        edges_q, edges_d;
  logic [8:0] rem_q, rem_d;      // toggles still owed, up to 2*255
  cnt_t       cnt_q, cnt_d;      // segment or settle countdown, ends at 1
  logic       lvl_q, lvl_d;
  cnt_t       width_q, width_d;
  cnt_t       settle_q, settle_d;
  logic       rand_q, rand_d;
  u32_t       lfsr_q;

  fltr_lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  function automatic cnt_t at_least_one(input cnt_t v);
    return (v == '0) ? cnt_t'(1) : v;
  endfunction

  function automatic cnt_t seg_len(input logic r, input cnt_t mw, input cnt_t rnd);
    return at_least_one(r ? (rnd & mw) : mw);
  endfunction

  function automatic u8_t sat_inc(input u8_t v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    edges_d  = edges_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    lvl_d    = lvl_q;
    width_d  = width_q;
    settle_d = settle_q;
    rand_d   = rand_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          lvl_d    = level_i;
          width_d  = max_width_i;
          settle_d = settle_i;
          rand_d   = rand_en_i;
          edges_d  = '0;
          if (level_i == sig_q) begin
            state_d = ST_DONE;
          end else begin
            sig_d   = ~sig_q;
            edges_d = 8'd1;
            // 2N+1 toggles in total; the one issued here is already spent.
            rem_d   = {n_bounce_i, 1'b0};
            if (n_bounce_i == '0) begin
              cnt_d   = at_least_one(settle_i);
              state_d = ST_SETTLE;
            end else begin
              cnt_d   = seg_len(rand_en_i, max_width_i, lfsr_q[W_CNT-1:0]);
              state_d = ST_SEG;
            end
          end
        end
      end

      ST_SEG: begin
        if (abort_i) begin
          sig_d   = lvl_q;
          if (sig_q != lvl_q) edges_d = sat_inc(edges_q);
          state_d = ST_DONE;
        end else if (cnt_q == cnt_t'(1)) begin
          sig_d   = ~sig_q;
          edges_d = sat_inc(edges_q);
          rem_d   = rem_q - 9'd1;
          if (rem_q == 9'd1) begin
            cnt_d   = at_least_one(settle_q);
            state_d = ST_SETTLE;
          end else begin
            cnt_d   = seg_len(rand_q, width_q, lfsr_q[W_CNT-1:0]);
          end
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end

      ST_SETTLE: begin
        if (abort_i || cnt_q == cnt_t'(1)) state_d = ST_DONE;
        else                               cnt_d   = cnt_q - cnt_t'(1);
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sig_q    <= RESET_LEVEL;
      edges_q  <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      lvl_q    <= RESET_LEVEL;
      width_q  <= '0;
      settle_q <= '0;
      rand_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      edges_q  <= edges_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      lvl_q    <= lvl_d;
      width_q  <= width_d;
      settle_q <= settle_d;
      rand_q   <= rand_d;
    end
  end

  assign sig_o   = sig_q;
  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = (state_q == ST_DONE);
  assign edges_o = edges_q;

endmodule
